matmul_sequencer: RTL and testbench

Controller that sequences a shared multiply-accumulate unit to compute the unsigned matrix product C = A × B for two N×N matrices. Both matrices are loaded into internal register storage through a write port. On a start pulse, the block walks every (row, col) pair, accumulates the N-term dot product of row i of A and column j of B, and streams each C element out through a valid/ready handshake. It sits between the host/testbench load logic and the downstream result consumer, and owns the single MAC datapath.

---
 rtl/matmul_pkg.sv | 16 +
 rtl/matmul_sequencer_mac.sv | 34 +++
 rtl/matmul_sequencer.sv | 151 +++++++++++++++
 tb/tb_matmul_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and width helpers for the matrix-multiply sequencer.
// Imported by the sequencer top and its MAC datapath.
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Wide enough to sum N full-scale products without overflow.
  function automatic int acc_width(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction

endpackage

// File: rtl/matmul_sequencer_mac.sv
// Single multiply-accumulate datapath shared by every dot product.
// Product is zero-extended to the accumulator width before the add.
module mac_unit
  import matmul_pkg::*;
#(
  parameter int DW   = 11,
  parameter int ACCW = 24
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clear,
  input  logic            en,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic [ACCW-1:0] acc
);

  logic [2*DW-1:0] prod;
  logic [ACCW-1:0] prod_x;

  assign prod   = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
  assign prod_x = {{(ACCW-2*DW){1'b0}}, prod};

  always_ff @(posedge clock) begin
    if (reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod_x;
    end
  end

endmodule

// File: rtl/matmul_sequencer.sv
// Sequences one MAC over every (row, col) of C = A x B and
// streams each element out through a valid/ready port.
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int N    = 4,
  parameter int DW   = 11,
  parameter int AW   = $clog2(N),
  parameter int ACCW = acc_width(N, DW)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            wr_en,
  input  logic            wr_sel,
  input  logic [AW-1:0]   wr_row,
  input  logic [AW-1:0]   wr_col,
  input  logic [DW-1:0]   wr_data,
  input  logic            start,
  output logic            busy,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [ACCW-1:0] res_data,
  output logic [AW-1:0]   res_row,
  output logic [AW-1:0]   res_col,
  output logic            done
);

  localparam logic [AW-1:0] LAST = AW'(N - 1);

  state_t state;
  state_t state_nxt;

  logic [DW-1:0]   mat_a [N][N];
  logic [DW-1:0]   mat_b [N][N];
  logic [AW-1:0]   i;
  logic [AW-1:0]   j;
  logic [AW-1:0]   k;
  logic [ACCW-1:0] acc;
  logic            mac_clr;
  logic            mac_en;
  logic            k_last;
  logic            j_last;
  logic            last_elem;
  logic            hs;
  logic            done_q;

  assign k_last    = (k == LAST);
  assign j_last    = (j == LAST);
  assign last_elem = (i == LAST) && j_last;
  assign hs        = (state == OUT) && res_ready;

  always_comb begin
    state_nxt = state;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ACC;
          mac_clr   = 1'b1;
        end
      end
      ACC: begin
        mac_en = 1'b1;
        if (k_last) state_nxt = OUT;
      end
      OUT: begin
        if (res_ready) begin
          mac_clr   = 1'b1;
          state_nxt = last_elem ? IDLE : ACC;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            i <= '0;
            j <= '0;
            k <= '0;
          end
        end
        ACC: begin
          k <= k_last ? '0 : k + 1'b1;
        end
        OUT: begin
          if (res_ready && !last_elem) begin
            if (j_last) begin
              j <= '0;
              i <= i + 1'b1;
            end else begin
              j <= j + 1'b1;
            end
          end
        end
        default: begin
          i <= '0;
          j <= '0;
          k <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) done_q <= 1'b0;
    else       done_q <= hs && last_elem;
  end

  // Storage is deliberately outside reset so matrices survive it.
  always_ff @(posedge clock) begin
    if (state == IDLE && wr_en) begin
      if (wr_sel) mat_b[wr_row][wr_col] <= wr_data;
      else        mat_a[wr_row][wr_col] <= wr_data;
    end
  end

  mac_unit #(
    .DW   (DW),
    .ACCW (ACCW)
  ) u_mac (
    .clock (clock),
    .reset (reset),
    .clear (mac_clr),
    .en    (mac_en),
    .a     (mat_a[i][k]),
    .b     (mat_b[k][j]),
    .acc   (acc)
  );

  assign busy      = (state != IDLE);
  assign res_valid = (state == OUT);
  assign res_data  = res_valid ? acc : '0;
  assign res_row   = res_valid ? i : '0;
  assign res_col   = res_valid ? j : '0;
  assign done      = done_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench: N=2 and N=4 sequencers, hand-computed products.
// Covers streaming order, timing, backpressure, busy lockout, reset.
module tb_matmul_sequencer;

  logic clock;
  logic reset;

  logic        wr_en2, wr_sel2, start2, res_ready2;
  logic [0:0]  wr_row2, wr_col2, res_row2, res_col2;
  logic [10:0] wr_data2;
  logic        busy2, res_valid2, done2;
  logic [22:0] res_data2;

  logic        wr_en4, wr_sel4, start4, res_ready4;
  logic [1:0]  wr_row4, wr_col4, res_row4, res_col4;
  logic [10:0] wr_data4;
  logic        busy4, res_valid4, done4;
  logic [23:0] res_data4;

  int n_tests;
  int n_fail;
  int exp4 [16];
  int bvals [16];

  matmul_sequencer #(.N(2)) u_n2 (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (wr_en2),
    .wr_sel    (wr_sel2),
    .wr_row    (wr_row2),
    .wr_col    (wr_col2),
    .wr_data   (wr_data2),
    .start     (start2),
    .busy      (busy2),
    .res_valid (res_valid2),
    .res_ready (res_ready2),
    .res_data  (res_data2),
    .res_row   (res_row2),
    .res_col   (res_col2),
    .done      (done2)
  );

  matmul_sequencer #(.N(4)) u_n4 (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (wr_en4),
    .wr_sel    (wr_sel4),
    .wr_row    (wr_row4),
    .wr_col    (wr_col4),
    .wr_data   (wr_data4),
    .start     (start4),
    .busy      (busy4),
    .res_valid (res_valid4),
    .res_ready (res_ready4),
    .res_data  (res_data4),
    .res_row   (res_row4),
    .res_col   (res_col4),
    .done      (done4)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load2(input logic sel, input int r, input int c,
                       input int d);
    wr_en2 = 1'b1; wr_sel2 = sel;
    wr_row2 = 1'(r); wr_col2 = 1'(c); wr_data2 = 11'(d);
    tick();
    wr_en2 = 1'b0;
  endtask

  task automatic load4(input logic sel, input int r, input int c,
                       input int d);
    wr_en4 = 1'b1; wr_sel4 = sel;
    wr_row4 = 2'(r); wr_col4 = 2'(c); wr_data4 = 11'(d);
    tick();
    wr_en4 = 1'b0;
  endtask

  task automatic run4(input int stall_idx, input int stall_n,
                      input bit poke, input int exp_last);
    int cyc, n, stalled, last_hs, done_cyc;
    logic [23:0] sd;
    logic [1:0]  sr, sc;
    sd = '0; sr = '0; sc = '0;
    n = 0; stalled = 0; last_hs = -1; done_cyc = -1;
    start4 = 1'b1;
    res_ready4 = 1'b1;
    tick();
    cyc = 1;
    start4 = 1'b0;
    chk("busy_rise", 32'(busy4), 1);
    while (cyc < 300 && done_cyc < 0) begin
      start4 = 1'b0;
      wr_en4 = 1'b0;
      res_ready4 = 1'b1;
      if (poke && cyc == 3) begin
        start4 = 1'b1; wr_en4 = 1'b1; wr_sel4 = 1'b0;
        wr_row4 = 2'd0; wr_col4 = 2'd0; wr_data4 = 11'd99;
      end
      if (done4) begin
        done_cyc = cyc;
        chk("busy_fall", 32'(busy4), 0);
      end else if (res_valid4) begin
        if (n == stall_idx && stalled < stall_n) begin
          if (stalled == 0) begin
            sd = res_data4; sr = res_row4; sc = res_col4;
          end else begin
            chk("stall_data", 32'(res_data4), 32'(sd));
            chk("stall_rc", {res_row4, res_col4}, {sr, sc});
          end
          res_ready4 = 1'b0;
          stalled++;
        end else begin
          chk("c_data", 32'(res_data4), 32'(exp4[n]));
          chk("c_row", 32'(res_row4), 32'(n / 4));
          chk("c_col", 32'(res_col4), 32'(n % 4));
          last_hs = cyc;
          n++;
        end
      end
      tick();
      cyc++;
    end
    start4 = 1'b0;
    wr_en4 = 1'b0;
    chk("elem_count", 32'(n), 16);
    chk("last_hs_cycle", 32'(last_hs), 32'(exp_last));
    chk("done_cycle", 32'(done_cyc), 32'(exp_last + 1));
    tick();
    chk("idle_after", {busy4, done4, res_valid4}, 0);
  endtask

  initial begin
    int cyc, n, last_hs, done_cyc;
    int exp2 [4];
    clock = 1'b0;
    reset = 1'b1;
    n_tests = 0; n_fail = 0;
    wr_en2 = 0; wr_sel2 = 0; wr_row2 = 0; wr_col2 = 0;
    wr_data2 = 0; start2 = 0; res_ready2 = 1;
    wr_en4 = 0; wr_sel4 = 0; wr_row4 = 0; wr_col4 = 0;
    wr_data4 = 0; start4 = 0; res_ready4 = 1;
    bvals = '{5, 100, 2047, 0, 17, 1, 33, 900,
              1234, 7, 64, 2000, 3, 511, 1024, 42};
    exp2 = '{19, 22, 43, 50};
    tick();
    tick();
    chk("rst_busy", 32'(busy4), 0);
    chk("rst_valid", 32'(res_valid4), 0);
    chk("rst_done", 32'(done4), 0);
    chk("rst_data", 32'(res_data4), 0);
    chk("rst_rc", {res_row4, res_col4}, 0);
    reset = 1'b0;
    tick();

    load2(0, 0, 0, 1); load2(0, 0, 1, 2);
    load2(0, 1, 0, 3); load2(0, 1, 1, 4);
    load2(1, 0, 0, 5); load2(1, 0, 1, 6);
    load2(1, 1, 0, 7); load2(1, 1, 1, 8);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    cyc = 1; n = 0; last_hs = -1; done_cyc = -1;
    while (cyc < 100 && done_cyc < 0) begin
      if (done2) begin
        done_cyc = cyc;
      end else if (res_valid2) begin
        chk("n2_data", 32'(res_data2), 32'(exp2[n]));
        chk("n2_rc", {res_row2, res_col2}, 32'(n));
        last_hs = cyc;
        n++;
      end
      tick();
      cyc++;
    end
    chk("n2_count", 32'(n), 4);
    chk("n2_last_hs", 32'(last_hs), 12);
    chk("n2_done", 32'(done_cyc), 13);

    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        load4(0, r, c, (r == c) ? 1 : 0);
        load4(1, r, c, bvals[r*4+c]);
        exp4[r*4+c] = bvals[r*4+c];
      end
    end
    run4(-1, 0, 0, 80);
    run4(1, 5, 0, 85);
    run4(-1, 0, 1, 80);
    run4(-1, 0, 0, 80);

    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        load4(0, r, c, 2047);
        load4(1, r, c, 2047);
        exp4[r*4+c] = 16760836;
      end
    end
    run4(-1, 0, 0, 80);

    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    chk("pre_rst_busy", 32'(busy4), 1);
    reset = 1'b1;
    tick();
    chk("mid_rst_busy", 32'(busy4), 0);
    chk("mid_rst_valid", 32'(res_valid4), 0);
    chk("mid_rst_done", 32'(done4), 0);
    chk("mid_rst_data", 32'(res_data4), 0);
    chk("mid_rst_rc", {res_row4, res_col4}, 0);
    reset = 1'b0;
    tick();
    run4(-1, 0, 0, 80);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
